// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 fetch-path types and constants.
package riscv_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // One buffered fetch result: instruction word and the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries. Flush wins over push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned  AW       = $clog2(DEPTH);
  localparam logic [AW:0]  CNT_FULL = (AW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == CNT_FULL);
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rptr];
  assign w_push = push & ~full & ~flush;
  assign w_pop  = pop & ~empty & ~flush;

  // Pointer and occupancy tracking; flush and reset both empty the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, imem request credits, stale-response dropping and the
// decode-facing instruction buffer.
// Optional FETCH_BYPASS_EN: an imem response may feed decode in the same
// cycle when the buffer is empty and nothing is being dropped.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_inst,
  output logic [XLEN-1:0] dec_pc
);

  localparam int unsigned CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(BUF_DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  fetch_entry_t    w_head;
  fetch_entry_t    w_push_data;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;
  logic            w_push;
  logic            w_pop;
  logic            w_req_fire;
  logic            w_rsp_drop;
  logic            w_rsp_keep;
  logic            w_bypass;
  logic [CW:0]     w_inflight;
  logic [XLEN-1:0] w_redirect_pc;

  assign w_redirect_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_rsp_drop    = imem_rsp_valid & (r_drop_cnt != '0);
  assign w_rsp_keep    = imem_rsp_valid & (r_drop_cnt == '0) & ~redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_empty & w_rsp_keep;
`else
  assign w_bypass = 1'b0;
`endif

  // With an empty buffer r_rsp_pc is the address of the next word to arrive,
  // so it doubles as the bypass pc and as the idle/reset dec_pc.
  assign dec_valid   = ~w_empty | w_bypass;
  assign dec_inst    = ~w_empty ? w_head.inst : (w_bypass ? imem_rsp_data : INST_NOP);
  assign dec_pc      = ~w_empty ? w_head.pc : r_rsp_pc;
  assign w_pop       = dec_valid & dec_ready & ~redirect_valid & ~w_empty;
  assign w_push      = w_rsp_keep & ~(w_bypass & dec_ready);
  assign w_push_data = '{inst: imem_rsp_data, pc: r_rsp_pc};

  // A slot being popped this cycle is counted as free: the response to any
  // request issued now lands no earlier than next cycle, after the pop.
  assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_count} - (CW+1)'(w_pop);
  assign imem_req_valid = rst_n & ~redirect_valid & (w_inflight < CREDITS);
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid & imem_req_ready;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .flush     (redirect_valid),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  // PC, outstanding-request and stale-response bookkeeping; redirect wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
        r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_rsp_keep) r_rsp_pc   <= r_rsp_pc + 32'd4;
        if (w_rsp_drop) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && w_full && !redirect_valid));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of decode and imm_gen. Holds the PC, issues word-aligned requests to instruction memory over a valid/ready handshake, and buffers returned words.
- Presents {inst, pc} to decode with a valid/ready handshake. Decode slices `inst` into imm_gen.
- On branch/jump redirect, flushes the buffer and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- BUF_DEPTH, 2, instruction buffer entries (power of two, >=2); also the max outstanding-plus-buffered count

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  imem accepts request
- imem_req_addr  output  32  fetch address, bits [1:0] always 0
- imem_rsp_valid  input  1  response word valid (in order, >=1 cycle after acceptance, no backpressure)
- imem_rsp_data  input  32  instruction word
- redirect_valid  input  1  branch/jump taken, one-cycle pulse
- redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 00)
- dec_valid  output  1  {dec_inst, dec_pc} valid
- dec_ready  input  1  decode consumes entry
- dec_inst  output  32  instruction to decode/imm_gen
- dec_pc  output  32  address of dec_inst

Behaviour:
- Reset (rst_n=0 at clk edge):
  - fetch_pc=RESET_PC and rsp_pc=RESET_PC.
  - Buffer is emptied; outstanding=0, drop_cnt=0.
  - dec_valid=0, dec_inst=32'h0000_0013 (NOP), dec_pc=RESET_PC.
  - imem_req_valid=0 during reset cycle.
  - A reset mid-transaction abandons all in-flight responses. imem must also be reset.
- Request issue:
  - imem_req_valid = rst_n & ~redirect_valid & (outstanding + occupancy < BUF_DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid&ready: fetch_pc += 4 (wraps mod 2^32) and outstanding += 1.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt>0: the response is discarded and drop_cnt -= 1.
  - Otherwise {imem_rsp_data, rsp_pc} is pushed to the buffer and rsp_pc += 4.
  - Credit rule guarantees the buffer never overflows. A push to a full buffer is an assertion failure.
- Decode side:
  - dec_valid = buffer non-empty; head entry drives dec_inst/dec_pc.
  - Pop on dec_valid & dec_ready.
  - Push and pop in the same cycle keeps occupancy unchanged.
  - dec_inst/dec_pc hold their value while dec_valid & ~dec_ready.
  - When empty, dec_inst = NOP.
- Redirect (priority over everything):
  - Buffer is flushed; any same-cycle dec handshake is irrelevant.
  - fetch_pc = rsp_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt = outstanding − (imem_rsp_valid this cycle). The same-cycle response is discarded.
  - No request is issued in the redirect cycle; the first new request goes out the next cycle.
- Back-to-back redirects: the second overrides the first; drop_cnt is recomputed from the current outstanding.
- Full buffer with dec_ready=0: requests stall via credits; no response is lost.
- Throughput: one instruction per cycle sustained when imem has 1-cycle latency and dec_ready=1.
- Min fetch-to-dec_valid latency: 2 cycles (request accepted at T, response at T+1, dec_valid at T+2).

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when buffer is empty, drop_cnt=0, no redirect and imem_rsp_valid=1, the response drives dec_valid/dec_inst/dec_pc combinationally in the same cycle.
  - If dec_ready=1 it is not written to the buffer.
  - Min latency becomes 1 cycle.
- Undefined: all responses go through the buffer (registered outputs, 2-cycle minimum latency).

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32, INST_NOP=32'h0000_0013, RESET_PC default
  - typedef fetch_entry_t {inst[31:0], pc[31:0]}
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH; ports push/pop/flush/full/empty/count.
  - Flush has priority over push.
  - Top level holds PC, credit, outstanding and drop logic.

Test Plan:
1. Reset with RESET_PC=32'h100, imem 1-cycle latency, dec_ready=1 → dec_pc sequence 0x100,0x104,0x108 on consecutive cycles; dec_inst matches memory.
2. dec_ready=0 for 10 cycles → imem_req_valid drops after 2 accepted requests; dec_inst/dec_pc held at 0x100. On release: 0x100, 0x104, 0x108 with no loss or duplication.
3. Redirect to 32'h200 with 2 outstanding (3-cycle imem latency) → both stale responses dropped; first dec_pc=0x200 carrying mem[0x200].
4. redirect_pc=32'h203 → imem_req_addr=0x200, dec_pc=0x200.
5. Redirect in the same cycle as imem_rsp_valid and dec handshake → that response never appears on dec_*; buffer empty next cycle.
6. fetch_pc=32'hFFFF_FFFC → next request address 32'h0000_0000. rst_n=0 mid-stream → all outputs at reset values next cycle; fetch restarts at RESET_PC.
